// File: rtl/rf_writeback_ctrl.sv
// Register-file write-side controller: two-producer arbitration, in-order
// write buffer, one write per clock, and forwarding lookup over pending writes.
module rf_writeback_ctrl #(
  parameter int DEPTH = 4,
  parameter int DW    = 32
) (
  input  logic                         Clk,
  input  logic                         Rst_n,
  input  logic                         mem_valid,
  output logic                         mem_ready,
  input  logic [3:0]                   mem_rd,
  input  logic [DW-1:0]                mem_data,
  input  logic                         alu_valid,
  output logic                         alu_ready,
  input  logic [3:0]                   alu_rd,
  input  logic [DW-1:0]                alu_data,
  input  logic                         wb_stall,
  output logic [3:0]                   RW,
  output logic [DW-1:0]                PW,
  output logic                         LE,
  input  logic [3:0]                   lk_addr,
  output logic                         lk_hit,
  output logic [DW-1:0]                lk_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         drop_r15
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [3:0]    rd;
    logic [DW-1:0] data;
  } wb_ent_t;

  wb_ent_t        ent_q [DEPTH];
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           drop_q, drop_d;

  logic           full, acc_mem, acc_alu, acc;
  logic           push, nonempty;
  wb_ent_t        enq, head;
  logic [AW-1:0]  idx;

  always_comb begin
    full      = (cnt_q == CW'(DEPTH));
    mem_ready = !full;
    alu_ready = !full && !mem_valid;
    acc_mem   = mem_valid && mem_ready;
    acc_alu   = alu_valid && alu_ready;
    acc       = acc_mem || acc_alu;
    enq       = acc_mem ? {mem_rd, mem_data} : {alu_rd, alu_data};
    // R15 is the PC: handshake completes but nothing is buffered
    push      = acc && (enq.rd != 4'hF);
    drop_d    = acc && (enq.rd == 4'hF);
    nonempty  = (cnt_q != '0);
    LE        = nonempty && !wb_stall;
    head      = ent_q[rd_ptr_q];
    RW        = nonempty ? head.rd : 4'h0;
    PW        = nonempty ? head.data : '0;
    rd_ptr_d  = LE ? rd_ptr_q + AW'(1) : rd_ptr_q;
    wr_ptr_d  = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    cnt_d     = cnt_q + CW'(push) - CW'(LE);
  end

  // Scan oldest to youngest so the youngest match wins
  always_comb begin
    lk_hit  = 1'b0;
    lk_data = '0;
    idx     = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr_q + AW'(k);
      if ((CW'(k) < cnt_q) && (ent_q[idx].rd == lk_addr) &&
          (lk_addr != 4'hF)) begin
        lk_hit  = 1'b1;
        lk_data = ent_q[idx].data;
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      drop_q   <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      drop_q   <= drop_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (push) ent_q[wr_ptr_q] <= enq;
  end

  assign count    = cnt_q;
  assign drop_r15 = drop_q;

endmodule
